sopc_nios_debug_cmd_sequencer: RTL and testbench
================================================

# sopc_nios_debug_cmd_sequencer

Command sequencer for the Nios II JTAG debug module, in the `clk` domain next to the system-clock half of the debug module. It captures the one-cycle `take_action_*` strobes and their `jdo` payload into a small FIFO. It then issues them one at a time to the on-chip-instrumentation resources (OCI memory, break registers, trace memory/control) over a valid/ready/done handshake. Back-to-back JTAG actions are therefore never lost while a slow target is still finishing the previous one.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2
- `DATA_W`, 38: payload width, equals `jdo` width
- `TIMEOUT`, 255: max cycles in WAIT before abort (used only with the timeout feature)

Ports:
- `clk` in 1: system clock; one clock domain only
- `reset` in 1: synchronous, active-high
- `jdo` in `DATA_W`: payload, sampled with any strobe
- `take_action` in 8: one-cycle strobes. Bit 0 ocimem_a, 1 ocimem_b, 2 break_a, 3 break_b, 4 break_c, 5 tracemem_a, 6 tracemem_b, 7 tracectrl
- `cmd_valid` out 1: command presented
- `cmd_op` out 3: index of the originating strobe bit
- `cmd_data` out `DATA_W`: captured `jdo`
- `cmd_ready` in 1: target accepts the command
- `cmd_done` in 1: target finished the accepted command
- `clear_status` in 1: clears the sticky flags
- `fifo_count` out `$clog2(DEPTH)+1`: queued entries
- `busy` out 1: `(state != IDLE) | (fifo_count != 0)`; derived only from registers
- `overflow` out 1: sticky; a strobe was dropped because the FIFO was full
- `collision` out 1: sticky; more than one strobe bit was set in the same cycle
- `timeout_err` out 1: sticky; a WAIT phase was aborted

## Operation
- Push: on any cycle with `take_action != 0`, enqueue {lowest set bit index, `jdo`}. If more than one bit is set, only the lowest index is enqueued and `collision` is set.
- Full: a push while full with no pop in the same cycle is dropped and sets `overflow`. A push and a pop in the same cycle while full is accepted.
- FSM states:
  - IDLE → ISSUE when `fifo_count != 0`. On this transition the head entry is loaded into `cmd_op`/`cmd_data` and popped.
  - ISSUE: `cmd_valid = 1`. `cmd_op` and `cmd_data` stay stable until accepted. ISSUE → WAIT on `cmd_valid & cmd_ready`.
  - WAIT: `cmd_valid = 0`. WAIT → IDLE on `cmd_done`.
- `cmd_done` is ignored outside WAIT, including in the accept cycle.
- Sticky flags: `clear_status` clears all three. If a set condition occurs in the same cycle as `clear_status`, the set wins.
- Reset:
  - `fifo_count = 0`, state IDLE.
  - `cmd_valid = 0`, `cmd_op = 0`, `cmd_data = 0`.
  - `busy = 0`, `overflow = 0`, `collision = 0`, `timeout_err = 0`.
  - Reset mid-operation abandons the in-flight command and all queued entries. `cmd_valid` is low after the reset edge.
  - Strobes are ignored during reset.
- Pointers wrap modulo `DEPTH`. The count ranges from 0 to `DEPTH` inclusive.

## Timing
- Strobe in cycle N: the entry is written at the end of N, and `fifo_count` is updated in N+1.
- With the FSM in IDLE and the FIFO empty, `cmd_valid` rises in cycle N+2. This is the minimum latency.
- Accept in cycle A → WAIT in A+1. `cmd_done` in cycle D → IDLE in D+1. Next `cmd_valid` in D+2 if the FIFO is non-empty.
- Peak throughput is one command per 3 cycles, with `cmd_ready` and `cmd_done` each asserted at first opportunity.
- `fifo_count` reflects the push and the pop of the same edge simultaneously.
- All outputs are registered or derived only from registers. There are no combinational input-to-output paths.

## Configuration
- `SOPC_NIOS_DEBUG_CMD_TIMEOUT_EN` defined:
  - A WAIT cycle counter is cleared on entering WAIT.
  - If `TIMEOUT` cycles elapse without `cmd_done`, the block sets `timeout_err` and moves to IDLE.
  - `cmd_done` arriving on the same cycle as the expiry counts as completion, with no error.
- Undefined: WAIT holds indefinitely. `timeout_err` is tied to 0 and the counter is not built.

## Test plan
- Single strobe: `take_action=8'h04` with `jdo=38'h1_2345_6789`, `cmd_ready=1`. Expect `cmd_valid` at N+2 with `cmd_op=2` and `cmd_data=38'h1_2345_6789`. Pulse `cmd_done` → `busy` falls.
- Collision: `take_action=8'h82`. Expect one entry with `cmd_op=1` and `collision=1`. Then `clear_status` → `collision=0`.
- Overflow: `DEPTH=4`, `cmd_ready=0`, six consecutive strobes. Expect one command held in ISSUE, `fifo_count=4`, `overflow=1`, and the 6th payload never issued.
- Backpressure: hold `cmd_ready=0` for 10 cycles. `cmd_op`/`cmd_data` stay stable. Accept, then wait 5 cycles and pulse `cmd_done`. Queued entries issue in FIFO order.
- Timeout (macro defined, `TIMEOUT=8`): accept a command and never assert `done`. Expect `timeout_err=1` and IDLE after 8 WAIT cycles, then the next entry issues.
- Reset mid-operation: assert `reset` in WAIT with 3 entries queued. Next cycle: `fifo_count=0`, `cmd_valid=0`, `busy=0`, all flags 0.

Source files
------------

// File: rtl/sopc_nios_debug_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// sopc_nios_debug_cmd_sequencer
//   Queues the debug module's take_action strobes with their jdo payload and
//   issues them one at a time to the OCI targets over valid/ready/done.
//   Optional WAIT-phase timeout: define SOPC_NIOS_DEBUG_CMD_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module sopc_nios_debug_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 38,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        jdo,
    input  logic [7:0]               take_action,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_op,
    output logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_ready,
    input  logic                     cmd_done,
    input  logic                     clear_status,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     collision,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              col_q, col_d;
    logic              tmo_q, tmo_d;

    logic [2:0]        w_push_op;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_multi;
    logic              w_full;
    logic              w_pop;
    logic              w_expire;

    always_comb begin
        w_push_op = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (take_action[i]) begin
                w_push_op = 3'(i);
            end
        end
    end

    assign w_push_req = |take_action;
    assign w_multi    = |(take_action & (take_action - 8'd1));
    assign w_full     = (count_q == CW'(DEPTH));
    assign w_pop      = (state_q == IDLE) && (count_q != '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

`ifdef SOPC_NIOS_DEBUG_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    assign wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + TW'(1) : '0;
    assign w_expire   = (state_q == WAIT) && !cmd_done &&
                        (wait_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (w_pop) begin
                    state_d        = ISSUE;
                    {op_d, data_d} = mem_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cmd_done || w_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = w_push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(w_push_ok) - CW'(w_pop);

        ovf_d = (ovf_q & ~clear_status) | (w_push_req & ~w_push_ok);
        col_d = (col_q & ~clear_status) | w_multi;
        tmo_d = (tmo_q & ~clear_status) | w_expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            col_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_q     <= op_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            col_q    <= col_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            mem_q[wr_ptr_q] <= {w_push_op, jdo};
        end
    end

    assign cmd_valid   = (state_q == ISSUE);
    assign cmd_op      = op_q;
    assign cmd_data    = data_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign overflow    = ovf_q;
    assign collision   = col_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_sopc_nios_debug_cmd_sequencer.sv
`default_nettype none
// Testbench for sopc_nios_debug_cmd_sequencer: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_sopc_nios_debug_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 38;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH) + 1;
`ifdef SOPC_NIOS_DEBUG_CMD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] jdo;
    logic [7:0]        take_action;
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              cmd_done;
    logic              clear_status;
    logic [CW-1:0]     fifo_count;
    logic              busy;
    logic              overflow;
    logic              collision;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    sopc_nios_debug_cmd_sequencer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .jdo(jdo), .take_action(take_action),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .clear_status(clear_status),
        .fifo_count(fifo_count), .busy(busy), .overflow(overflow),
        .collision(collision), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending queue, one in-flight command, phase 0/1/2 = idle/offered/awaiting done.
    logic [DATA_W+2:0] m_q[$];
    int                m_phase = 0;
    int                m_wait  = 0;
    logic [2:0]        m_op    = '0;
    logic [DATA_W-1:0] m_data  = '0;
    bit                m_ovf = 0, m_col = 0, m_tmo = 0;

    task automatic model_step();
        bit set_ovf = 0, set_col = 0, set_tmo = 0;
        int lo = 0;
        if (reset) begin
            m_q.delete();
            m_phase = 0; m_wait = 0; m_op = '0; m_data = '0;
            m_ovf = 0; m_col = 0; m_tmo = 0;
            return;
        end
        if (m_phase == 0) begin
            if (m_q.size() > 0) begin
                {m_op, m_data} = m_q.pop_front();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (cmd_ready) begin m_phase = 2; m_wait = 0; end
        end else begin
            m_wait++;
            if (cmd_done) m_phase = 0;
            else if (TMO_EN && m_wait == TIMEOUT) begin m_phase = 0; set_tmo = 1; end
        end
        if (take_action != 8'h00) begin
            for (int i = 7; i >= 0; i--) if (take_action[i]) lo = i;
            if ($countones(take_action) > 1) set_col = 1;
            if (m_q.size() < DEPTH) m_q.push_back({3'(lo), jdo});
            else set_ovf = 1;
        end
        if (clear_status) begin m_ovf = 0; m_col = 0; m_tmo = 0; end
        m_ovf |= set_ovf; m_col |= set_col; m_tmo |= set_tmo;
    endtask

    task automatic tick(input logic [7:0] ta, input logic [DATA_W-1:0] d, input logic rdy,
                        input logic dn, input logic clr, input logic rst);
        take_action = ta; jdo = d; cmd_ready = rdy; cmd_done = dn;
        clear_status = clr; reset = rst;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic test_reset();
        tick(8'h00, '0, 0, 0, 0, 1);
        tick(8'h5A, '1, 1, 1, 1, 1);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cmd_valid); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if ({overflow, collision, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {overflow, collision, timeout_err}); end
        checks++; if ({cmd_op, cmd_data} !== '0) begin errors++; $display("FAIL reset_cmd: got op=%0d data=%h want 0", cmd_op, cmd_data); end
        tick(8'h00, '0, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        tick(8'h04, 38'h1_2345_6789, 1, 0, 0, 0);
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", cmd_valid); end
        tick(8'h00, '0, 1, 0, 0, 0);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", cmd_valid); end
        checks++; if (cmd_op !== 3'd2) begin errors++; $display("FAIL single_op: got %0d want 2", cmd_op); end
        checks++; if (cmd_data !== 38'h1_2345_6789) begin errors++; $display("FAIL single_data: got %h want 1_2345_6789", cmd_data); end
        tick(8'h00, '0, 1, 1, 0, 0);
        checks++; if ({cmd_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_wait: got valid,busy=%b want 01", {cmd_valid, busy}); end
        tick(8'h00, '0, 1, 1, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b want 0", busy); end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d = rnd_data();
        tick(8'h82, d, 0, 0, 0, 0);
        checks++; if ({collision, fifo_count} !== {1'b1, CW'(1)}) begin errors++; $display("FAIL coll_set: got col=%0b count=%0d want 1/1", collision, fifo_count); end
        tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd1, d}) begin errors++; $display("FAIL coll_issue: got v=%0b op=%0d data=%h want 1/1/%h", cmd_valid, cmd_op, cmd_data, d); end
        tick(8'h00, '0, 1, 0, 0, 0);
        tick(8'h00, '0, 0, 1, 0, 0);
        tick(8'h00, '0, 0, 0, 1, 0);
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %0b want 0", collision); end
        tick(8'h0C, d, 0, 0, 1, 0);
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got %0b want 1", collision); end
        tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if (cmd_op !== 3'd2) begin errors++; $display("FAIL coll_op2: got %0d want 2", cmd_op); end
        tick(8'h00, '0, 1, 0, 0, 0);
        tick(8'h00, '0, 0, 1, 0, 0);
        tick(8'h00, '0, 0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] p[6];
        logic [DATA_W-1:0] got[$];
        for (int k = 0; k < 6; k++) p[k] = rnd_data();
        for (int k = 0; k < 6; k++) tick(8'h20, p[k], 0, 0, 0, 0);
        checks++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        checks++; if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd5, p[0]}) begin errors++; $display("FAIL ovf_head: got v=%0b op=%0d data=%h want 1/5/%h", cmd_valid, cmd_op, cmd_data, p[0]); end
        for (int c = 0; c < 40; c++) begin
            if (cmd_valid) got.push_back(cmd_data);
            tick(8'h00, '0, 1, 1, 0, 0);
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL ovf_issued_n: got %0d want 5", got.size()); end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            checks++; if (got[k] !== p[k]) begin errors++; $display("FAIL ovf_order[%0d]: got %h want %h", k, got[k], p[k]); end
        end
    endtask

    task automatic test_reset_mid();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf: got %0b want 1", overflow); end
        for (int k = 0; k < 4; k++) tick(8'h08, rnd_data(), 0, 0, 0, 0);
        tick(8'h00, '0, 1, 0, 0, 0);
        checks++; if ({cmd_valid, busy, fifo_count} !== {1'b0, 1'b1, CW'(3)}) begin errors++; $display("FAIL mid_pre_wait: got v=%0b busy=%0b count=%0d want 0/1/3", cmd_valid, busy, fifo_count); end
        tick(8'hFF, rnd_data(), 1, 0, 0, 1);
        checks++; if ({cmd_valid, busy, fifo_count} !== {1'b0, 1'b0, CW'(0)}) begin errors++; $display("FAIL mid_reset: got v=%0b busy=%0b count=%0d want 0/0/0", cmd_valid, busy, fifo_count); end
        checks++; if ({overflow, collision, timeout_err, cmd_op, cmd_data} !== '0) begin errors++; $display("FAIL mid_reset_regs: got flags=%b op=%0d data=%h want 0", {overflow, collision, timeout_err}, cmd_op, cmd_data); end
        tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if ({cmd_valid, fifo_count} !== {1'b0, CW'(0)}) begin errors++; $display("FAIL mid_after: got v=%0b count=%0d want 0/0", cmd_valid, fifo_count); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] e[3];
        logic [DATA_W-1:0] got[$];
        for (int k = 0; k < 3; k++) e[k] = rnd_data();
        for (int k = 0; k < 3; k++) tick(8'h40, e[k], 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            checks++; if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd6, e[0]}) begin errors++; $display("FAIL bp_hold[%0d]: got v=%0b op=%0d data=%h want 1/6/%h", c, cmd_valid, cmd_op, cmd_data, e[0]); end
            tick(8'h00, '0, 0, 0, 0, 0);
        end
        tick(8'h00, '0, 1, 0, 0, 0);
        for (int c = 0; c < 5; c++) tick(8'h00, '0, 1, 0, 0, 0);
        checks++; if ({cmd_valid, busy} !== 2'b01) begin errors++; $display("FAIL bp_wait: got v,busy=%b want 01", {cmd_valid, busy}); end
        tick(8'h00, '0, 0, 1, 0, 0);
        for (int c = 0; c < 20; c++) begin
            if (cmd_valid) got.push_back(cmd_data);
            tick(8'h00, '0, 1, 1, 0, 0);
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL bp_issued_n: got %0d want 2", got.size()); end
        for (int k = 0; k < got.size() && k < 2; k++) begin
            checks++; if (got[k] !== e[k+1]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], e[k+1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] f[6];
        logic [DATA_W-1:0] got[$];
        for (int k = 0; k < 6; k++) f[k] = rnd_data();
        tick(8'h02, f[0], 0, 0, 0, 0);
        tick(8'h00, '0, 0, 0, 0, 0);
        tick(8'h00, '0, 1, 0, 0, 0);
        for (int k = 1; k < 5; k++) tick(8'h02, f[k], 0, 0, 0, 0);
        checks++; if ({fifo_count, overflow} !== {CW'(4), 1'b0}) begin errors++; $display("FAIL b2b_fill: got count=%0d ovf=%0b want 4/0", fifo_count, overflow); end
        tick(8'h00, '0, 0, 1, 0, 0);
        tick(8'h02, f[5], 0, 0, 0, 0);
        checks++; if ({fifo_count, overflow} !== {CW'(4), 1'b0}) begin errors++; $display("FAIL b2b_full_pop: got count=%0d ovf=%0b want 4/0", fifo_count, overflow); end
        for (int c = 0; c < 30; c++) begin
            if (cmd_valid) got.push_back(cmd_data);
            tick(8'h00, '0, 1, 1, 0, 0);
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_issued_n: got %0d want 5", got.size()); end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            checks++; if (got[k] !== f[k+1]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", k, got[k], f[k+1]); end
        end
    endtask

    task automatic test_timeout();
`ifdef SOPC_NIOS_DEBUG_CMD_TIMEOUT_EN
        logic [DATA_W-1:0] t0 = rnd_data();
        logic [DATA_W-1:0] t1 = rnd_data();
        tick(8'h80, t0, 0, 0, 0, 0);
        tick(8'h80, t1, 0, 0, 0, 0);
        tick(8'h00, '0, 1, 0, 0, 0);
        for (int c = 0; c < TIMEOUT - 1; c++) tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if ({cmd_valid, busy, timeout_err} !== 3'b010) begin errors++; $display("FAIL tmo_before: got v,busy,tmo=%b want 010", {cmd_valid, busy, timeout_err}); end
        tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b want 1", timeout_err); end
        tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if ({cmd_valid, cmd_data} !== {1'b1, t1}) begin errors++; $display("FAIL tmo_next: got v=%0b data=%h want 1/%h", cmd_valid, cmd_data, t1); end
        tick(8'h00, '0, 1, 0, 1, 0);
        for (int c = 0; c < TIMEOUT - 1; c++) tick(8'h00, '0, 0, 0, 0, 0);
        tick(8'h00, '0, 0, 1, 0, 0);
        checks++; if ({busy, timeout_err} !== 2'b00) begin errors++; $display("FAIL tmo_done_at_expiry: got busy,tmo=%b want 00", {busy, timeout_err}); end
`else
        tick(8'h80, rnd_data(), 0, 0, 0, 0);
        tick(8'h00, '0, 0, 0, 0, 0);
        tick(8'h00, '0, 1, 0, 0, 0);
        for (int c = 0; c < 40; c++) tick(8'h00, '0, 0, 0, 0, 0);
        checks++; if ({cmd_valid, busy, timeout_err} !== 3'b010) begin errors++; $display("FAIL wait_hold: got v,busy,tmo=%b want 010", {cmd_valid, busy, timeout_err}); end
        tick(8'h00, '0, 0, 1, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_done: got %0b want 0", busy); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ta;
        int r;
        tick(8'h00, '0, 0, 0, 0, 1);
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r < 4) ta = 8'h00;
            else if (r < 8) ta = 8'h01 << $urandom_range(0, 7);
            else ta = 8'($urandom());
            tick(ta, rnd_data(), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
            checks++; if (cmd_valid !== (m_phase == 1)) begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", c, cmd_valid, (m_phase == 1)); end
            checks++; if ({cmd_op, cmd_data} !== {m_op, m_data}) begin errors++; $display("FAIL rnd_cmd @%0d: got op=%0d data=%h want op=%0d data=%h", c, cmd_op, cmd_data, m_op, m_data); end
            checks++; if (fifo_count !== CW'(m_q.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, fifo_count, m_q.size()); end
            checks++; if (busy !== (m_phase != 0 || m_q.size() != 0)) begin errors++; $display("FAIL rnd_busy @%0d: got %0b", c, busy); end
            checks++; if ({overflow, collision, timeout_err} !== {m_ovf, m_col, m_tmo}) begin errors++; $display("FAIL rnd_flags @%0d: got %b want %b", c, {overflow, collision, timeout_err}, {m_ovf, m_col, m_tmo}); end
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; jdo = '0; take_action = '0;
        cmd_ready = 1'b0; cmd_done = 1'b0; clear_status = 1'b0;
        test_reset();
        test_single();
        test_collision();
        test_overflow();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
